btb_write: RTL and testbench

BTB_WRITE -- requirements
Module: btb_write

---
 rtl/btb_write.sv | 208 ++++++++++++++++++++
 tb/tb_btb_write.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_write.sv
// Branch target buffer write side: 8 sets x 2 ways, two-stage update pipeline,
// per-set MRU tracking and a sequential whole-array flush.
module btb_write (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   rd_index,
    output logic [127:0] rd_set,
    output logic [7:0]   lru,
    input  logic         if_hit,
    input  logic [2:0]   if_index,
    input  logic         if_next_lru,
    input  logic         upd_valid,
    output logic         upd_ready,
    input  logic [31:0]  upd_pc,
    input  logic         upd_taken,
    input  logic [31:0]  upd_target,
    input  logic         flush_req,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;

    logic [63:0] way1_q [8];
    logic [63:0] way2_q [8];
    logic [7:0]  lru_q;

    logic        s2_valid_q;
    logic [2:0]  s2_index_q;
    logic        s2_way_q;
    logic [63:0] s2_entry_q;

    logic [2:0]  upd_index;
    logic [26:0] upd_tag;
    logic [63:0] view1;
    logic [63:0] view2;
    logic        view_lru;
    logic        hit1;
    logic        hit2;
    logic [31:0] hit_target;
    logic [1:0]  hit_state;
    logic        new_write;
    logic        new_way;
    logic [63:0] new_entry;
    logic        accept;
    logic        unused_bits;

    // Handshake: an update transfers on a rising edge where upd_valid && upd_ready;
    // upd_ready is withheld during reset, during a flush and when a flush is requested.
    assign busy      = (state_q == FLUSH);
    assign upd_ready = !rst && !busy && !flush_req;
    assign accept    = upd_valid && upd_ready;

    assign rd_set = {way1_q[rd_index], way2_q[rd_index]};
    assign lru    = lru_q;

    assign upd_index   = upd_pc[4:2];
    assign upd_tag     = upd_pc[31:5];
    assign unused_bits = ^{upd_pc[1:0], view1[1:0], view2[1:0]};

    function automatic logic [1:0] step_state(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            case (cur)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                default: nxt = 2'b10;
            endcase
        end else begin
            case (cur)
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

    // S1 view of the set: the write sitting in S2 has not reached the array yet.
    always_comb begin
        view1    = way1_q[upd_index];
        view2    = way2_q[upd_index];
        view_lru = lru_q[upd_index];
        if (s2_valid_q && (s2_index_q == upd_index)) begin
            if (s2_way_q) begin
                view2 = s2_entry_q;
            end else begin
                view1 = s2_entry_q;
            end
            view_lru = s2_way_q;
        end
    end

    assign hit1       = view1[63] && (view1[62:36] == upd_tag);
    assign hit2       = view2[63] && (view2[62:36] == upd_tag);
    assign hit_target = hit1 ? view1[35:4] : view2[35:4];
    assign hit_state  = hit1 ? view1[3:2]  : view2[3:2];

    always_comb begin
        new_write = 1'b0;
        new_way   = 1'b0;
        new_entry = '0;
        if (hit1 || hit2) begin
            new_write = 1'b1;
            new_way   = !hit1;
            new_entry = {1'b1, upd_tag,
                         (upd_taken ? upd_target : hit_target),
                         step_state(hit_state, upd_taken), 2'b00};
        end else if (upd_taken) begin
            new_write = 1'b1;
            if (!view1[63]) begin
                new_way = 1'b0;
            end else if (!view2[63]) begin
                new_way = 1'b1;
            end else begin
                new_way = !view_lru;
            end
            new_entry = {1'b1, upd_tag, upd_target, 2'b11, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_index_q <= '0;
            s2_way_q   <= 1'b0;
            s2_entry_q <= '0;
        end else begin
            s2_valid_q <= accept && new_write;
            if (accept) begin
                s2_index_q <= upd_index;
                s2_way_q   <= new_way;
                s2_entry_q <= new_entry;
            end
        end
    end

    // Later assignments win: the S2 LRU value overrides an IF hit on the same set,
    // and the flush clear overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                way1_q[i] <= '0;
                way2_q[i] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (if_hit) begin
                lru_q[if_index] <= if_next_lru;
            end
            if (s2_valid_q) begin
                if (s2_way_q) begin
                    way2_q[s2_index_q] <= s2_entry_q;
                end else begin
                    way1_q[s2_index_q] <= s2_entry_q;
                end
                lru_q[s2_index_q] <= s2_way_q;
            end
            if (state_q == FLUSH) begin
                way1_q[cnt_q][63] <= 1'b0;
                way2_q[cnt_q][63] <= 1'b0;
                lru_q[cnt_q]      <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_btb_write.sv
// Directed bench for btb_write: allocation, counter walk, victim choice, LRU
// arbitration, flush and reset-during-flush.
module tb_btb_write;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   rd_index = '0;
    logic [127:0] rd_set;
    logic [7:0]   lru;
    logic         if_hit = 1'b0;
    logic [2:0]   if_index = '0;
    logic         if_next_lru = 1'b0;
    logic         upd_valid = 1'b0;
    logic         upd_ready;
    logic [31:0]  upd_pc = '0;
    logic         upd_taken = 1'b0;
    logic [31:0]  upd_target = '0;
    logic         flush_req = 1'b0;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    btb_write dut (
        .clk         (clk),
        .rst         (rst),
        .rd_index    (rd_index),
        .rd_set      (rd_set),
        .lru         (lru),
        .if_hit      (if_hit),
        .if_index    (if_index),
        .if_next_lru (if_next_lru),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush_req   (flush_req),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ent(input logic [26:0] tag, input logic [31:0] tgt,
                                        input logic [1:0] st);
        return {1'b1, tag, tgt, st, 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idx(input logic [2:0] idx);
        rd_index = idx;
        #1;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
    endtask

    task automatic idle_upd();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (upd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_upd_ready_low: got %b expected 0", upd_ready);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (lru !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_lru: got %h expected 00", lru);
        end
        for (int i = 0; i < 8; i++) begin
            set_idx(i[2:0]);
            tests_run++;
            if (rd_set !== 128'h0) begin
                tests_failed++;
                $display("FAIL reset_set%0d: got %h expected 0", i, rd_set);
            end
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (upd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", upd_ready);
        end
        step();
    endtask

    task automatic test_allocate();
        drive_upd(32'h0000_1004, 1'b1, 32'h0000_2000);
        if_hit = 1'b1; if_index = 3'd1; if_next_lru = 1'b1;
        step();
        idle_upd();
        if_hit = 1'b0;
        set_idx(3'd1);
        tests_run++;
        if (rd_set !== 128'h0) begin
            tests_failed++;
            $display("FAIL alloc_not_forwarded: got %h expected 0", rd_set);
        end
        tests_run++;
        if (lru[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL alloc_if_hit_lru: got %b expected 1", lru[1]);
        end
        step();
        tests_run++;
        if (rd_set[127:64] !== ent(27'h80, 32'h0000_2000, 2'b11)) begin
            tests_failed++;
            $display("FAIL alloc_way1: got %h expected %h", rd_set[127:64],
                     ent(27'h80, 32'h0000_2000, 2'b11));
        end
        tests_run++;
        if (rd_set[63:0] !== 64'h0) begin
            tests_failed++;
            $display("FAIL alloc_way2: got %h expected 0", rd_set[63:0]);
        end
        tests_run++;
        if (lru[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL alloc_lru: got %b expected 0", lru[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_st [7];
        logic [31:0] exp_tgt;
        exp_st = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
        set_idx(3'd3);
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                drive_upd(32'h0000_300C, 1'b1, 32'(32'h4000 + i * 16));
            end else if (i < 7) begin
                drive_upd(32'h0000_300C, 1'b0, 32'hDEAD_0000);
            end else begin
                idle_upd();
            end
            if (i < 7) begin
                tests_run++;
                if (upd_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL walk_ready%0d: got %b expected 1", i, upd_ready);
                end
            end
            step();
            if (i >= 1) begin
                exp_tgt = (i - 1 < 5) ? 32'(32'h4000 + (i - 1) * 16) : 32'h0000_4040;
                tests_run++;
                if (rd_set[127:64] !== ent(27'h180, exp_tgt, exp_st[i-1])) begin
                    tests_failed++;
                    $display("FAIL walk_update%0d: got %h expected %h", i - 1, rd_set[127:64],
                             ent(27'h180, exp_tgt, exp_st[i-1]));
                end
            end
        end
        tests_run++;
        if (rd_set[63:0] !== 64'h0 || lru[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL walk_way2_lru: got way2=%h lru3=%b expected 0/0", rd_set[63:0], lru[3]);
        end
    endtask

    task automatic test_victim();
        drive_upd(32'h0000_0008, 1'b1, 32'h1111_0000);
        step();
        drive_upd(32'h0000_0028, 1'b1, 32'h2222_0000);
        step();
        idle_upd();
        step();
        set_idx(3'd2);
        tests_run++;
        if (rd_set !== {ent(27'h0, 32'h1111_0000, 2'b11), ent(27'h1, 32'h2222_0000, 2'b11)}) begin
            tests_failed++;
            $display("FAIL victim_fill: got %h", rd_set);
        end
        tests_run++;
        if (lru[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL victim_fill_lru: got %b expected 1", lru[2]);
        end
        drive_upd(32'h0000_0048, 1'b1, 32'h0000_9000);
        step();
        idle_upd();
        if_hit = 1'b1; if_index = 3'd2; if_next_lru = 1'b1;
        step();
        if_hit = 1'b0;
        tests_run++;
        if (rd_set !== {ent(27'h2, 32'h0000_9000, 2'b11), ent(27'h1, 32'h2222_0000, 2'b11)}) begin
            tests_failed++;
            $display("FAIL victim_replace: got %h", rd_set);
        end
        tests_run++;
        if (lru[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL victim_lru_override: got %b expected 0", lru[2]);
        end
    endtask

    task automatic test_lru_sets();
        if_hit = 1'b1; if_index = 3'd3; if_next_lru = 1'b1;
        step();
        if_hit = 1'b0;
        tests_run++;
        if (lru[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL lru_if_hit3: got %b expected 1", lru[3]);
        end
        drive_upd(32'h0000_300C, 1'b1, 32'h0000_5000);
        step();
        idle_upd();
        if_hit = 1'b1; if_index = 3'd6; if_next_lru = 1'b1;
        step();
        if_hit = 1'b0;
        set_idx(3'd3);
        tests_run++;
        if (lru[3] !== 1'b0 || lru[6] !== 1'b1) begin
            tests_failed++;
            $display("FAIL lru_diff_sets: got lru3=%b lru6=%b expected 0/1", lru[3], lru[6]);
        end
        tests_run++;
        if (rd_set[127:64] !== ent(27'h180, 32'h0000_5000, 2'b11)) begin
            tests_failed++;
            $display("FAIL lru_hit_update: got %h expected %h", rd_set[127:64],
                     ent(27'h180, 32'h0000_5000, 2'b11));
        end
    endtask

    task automatic test_nt_miss();
        if_hit = 1'b1; if_index = 3'd5; if_next_lru = 1'b1;
        step();
        if_hit = 1'b0;
        drive_upd(32'h0000_0014, 1'b0, 32'h0000_7777);
        step();
        idle_upd();
        step();
        set_idx(3'd5);
        tests_run++;
        if (rd_set !== 128'h0 || lru[5] !== 1'b1) begin
            tests_failed++;
            $display("FAIL nt_miss: got set=%h lru5=%b expected 0/1", rd_set, lru[5]);
        end
    endtask

    task automatic test_flush();
        int busy_cnt;
        drive_upd(32'h0000_0010, 1'b1, 32'h0000_A000);
        step();
        flush_req = 1'b1;
        #1;
        tests_run++;
        if (upd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_req_blocks_ready: got %b expected 0", upd_ready);
        end
        step();
        flush_req = 1'b0;
        set_idx(3'd4);
        tests_run++;
        if (rd_set[127:64] !== ent(27'h0, 32'h0000_A000, 2'b11)) begin
            tests_failed++;
            $display("FAIL flush_pending_write: got %h expected %h", rd_set[127:64],
                     ent(27'h0, 32'h0000_A000, 2'b11));
        end
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy !== 1'b1) break;
            busy_cnt++;
            flush_req = (k == 3);
            #1;
            tests_run++;
            if (upd_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_ready_low%0d: got %b expected 0", k, upd_ready);
            end
            step();
        end
        flush_req = 1'b0;
        idle_upd();
        tests_run++;
        if (busy_cnt != 8) begin
            tests_failed++;
            $display("FAIL flush_busy_cycles: got %0d expected 8", busy_cnt);
        end
        tests_run++;
        if (lru !== 8'h00) begin
            tests_failed++;
            $display("FAIL flush_lru: got %h expected 00", lru);
        end
        for (int i = 0; i < 8; i++) begin
            set_idx(i[2:0]);
            tests_run++;
            if (rd_set[127] !== 1'b0 || rd_set[63] !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_valid_set%0d: got %b%b expected 00", i, rd_set[127], rd_set[63]);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        drive_upd(32'h0000_0018, 1'b1, 32'h0000_B000);
        step();
        idle_upd();
        if_hit = 1'b1; if_index = 3'd7; if_next_lru = 1'b1;
        step();
        if_hit = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (4) step();
        set_idx(3'd6);
        tests_run++;
        if (busy !== 1'b1 || rd_set[127] !== 1'b1 || lru[7] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midflush_pre: got busy=%b v6=%b lru7=%b expected 1/1/1",
                     busy, rd_set[127], lru[7]);
        end
        rst = 1'b1;
        step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midflush_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (upd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midflush_ready_in_rst: got %b expected 0", upd_ready);
        end
        tests_run++;
        if (lru !== 8'h00) begin
            tests_failed++;
            $display("FAIL midflush_lru: got %h expected 00", lru);
        end
        for (int i = 0; i < 8; i++) begin
            set_idx(i[2:0]);
            tests_run++;
            if (rd_set !== 128'h0) begin
                tests_failed++;
                $display("FAIL midflush_set%0d: got %h expected 0", i, rd_set);
            end
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (upd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midflush_ready_after: got %b expected 1", upd_ready);
        end
        step();
        tests_run++;
        if (busy !== 1'b0 || upd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midflush_idle: got busy=%b ready=%b expected 0/1", busy, upd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_back_to_back();
        test_victim();
        test_lru_sets();
        test_nt_miss();
        test_flush();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
